// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, under a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | one MUL/DIV iteration per cycle until count hits zero
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [SHW:0]       count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic               op_mul;

  logic               accept_single, load, finish, is_iter;

  logic [SHW-1:0]     amt;
  logic [SHW:0]       amt_inv;
  logic [WIDTH:0]     add_full, sub_full;
  logic [WIDTH-1:0]   s_res;
  logic               s_c, s_v;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, iter_next;
  logic               iter_cv;

  // Single-cycle datapath, evaluated straight from the operand inputs.
  always_comb begin
    amt      = valB[SHW-1:0];
    amt_inv  = (SHW+1)'(WIDTH) - {1'b0, amt};
    add_full = {1'b0, valA} + {1'b0, valB};
    sub_full = {1'b0, valA} - {1'b0, valB};
    s_res    = '0;
    s_c      = 1'b0;
    s_v      = 1'b0;
    case (aluop)
      OP_ADD: begin
        s_res = add_full[WIDTH-1:0];
        s_c   = add_full[WIDTH];
        s_v   = (valA[WIDTH-1] == valB[WIDTH-1]) && (add_full[WIDTH-1] != valA[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = sub_full[WIDTH-1:0];
        s_c   = sub_full[WIDTH];
        s_v   = (valA[WIDTH-1] != valB[WIDTH-1]) && (sub_full[WIDTH-1] != valA[WIDTH-1]);
      end
      OP_DIV: begin
        s_res = '1;
        s_v   = 1'b1;
      end
      OP_SHL:  s_res = valA << amt;
      OP_SHAR: s_res = $signed(valA) >>> amt;
      OP_SHLR: s_res = valA >> amt;
      OP_RL:   s_res = (valA << amt) | (valA >> amt_inv);
      OP_RR:   s_res = (valA >> amt) | (valA << amt_inv);
      OP_AND:  s_res = valA & valB;
      OP_OR:   s_res = valA | valB;
      OP_XOR:  s_res = valA ^ valB;
      OP_NOT:  s_res = ~valB;
      default: s_res = '0;
    endcase
  end

  // One iteration step; acc holds {high, low} for MUL and {rem, quo} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opd};
    div_next  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    iter_next = op_mul ? mul_next : div_next;
    iter_cv   = op_mul && (|iter_next[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept_single = 1'b0;
    load          = 1'b0;
    finish        = 1'b0;
    busy          = 1'b0;
    is_iter       = (aluop == OP_MUL) || ((aluop == OP_DIV) && (valB != '0));
    case (state)
      IDLE: begin
        if (start) begin
          if (is_iter) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            accept_single = 1'b1;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == (SHW+1)'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      cc     <= 4'b0000;
      count  <= '0;
      acc    <= '0;
      opd    <= '0;
      op_mul <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_single) begin
        result <= s_res;
        cc     <= {s_res[WIDTH-1], s_res == '0, s_c, s_v};
        done   <= 1'b1;
      end
      if (load) begin
        op_mul <= (aluop == OP_MUL);
        acc    <= {{WIDTH{1'b0}}, (aluop == OP_MUL) ? valB : valA};
        opd    <= (aluop == OP_MUL) ? valA : valB;
        count  <= (SHW+1)'(WIDTH);
      end
      if (state == RUN) begin
        acc   <= iter_next;
        count <= count - 1'b1;
        if (finish) begin
          result <= iter_next[WIDTH-1:0];
          cc     <= {iter_next[WIDTH-1], iter_next[WIDTH-1:0] == '0, iter_cv, iter_cv};
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: WIDTH=16 instance for the main plan,
// WIDTH=8 instance for the narrow multiply.
module tb_seq_alu;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  aluop;
  logic [15:0] valA, valB, result;
  logic        busy, done;
  logic [3:0]  cc;

  logic        start8;
  logic [3:0]  aluop8;
  logic [7:0]  valA8, valB8, result8;
  logic        busy8, done8;
  logic [3:0]  cc8;

  int total  = 0;
  int passed = 0;
  int bc;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .valA(valA), .valB(valB),
    .busy(busy), .done(done), .result(result), .cc(cc)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .aluop(aluop8), .valA(valA8), .valB(valB8),
    .busy(busy8), .done(done8), .result(result8), .cc(cc8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic [3:0] c);
    chk({tag, "_done"},   32'(done),   32'(1'b1));
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_cc"},     32'(cc),     32'(c));
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    aluop = op;
    valA  = a;
    valB  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; aluop = '0; valA = '0; valB = '0;
    start8 = 1'b0; aluop8 = '0; valA8 = '0; valB8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",    32'(busy),    0);
    chk("rst_done",    32'(done),    0);
    chk("rst_result",  32'(result),  0);
    chk("rst_cc",      32'(cc),      0);
    chk("rst_result8", 32'(result8), 0);
    reset = 1'b0;

    issue(OP_ADD, 16'h7FFF, 16'h0001);
    chk_out("add_ovf", 16'h8000, 4'b1001);
    @(negedge clk);
    chk("done_pulse_width", 32'(done),   0);
    chk("result_hold",      32'(result), 32'h8000);

    issue(OP_ADD, 16'hFFFF, 16'h0001);
    chk_out("add_carry", 16'h0000, 4'b0110);
    issue(OP_SUB, 16'h0003, 16'h0005);
    chk_out("sub_borrow", 16'hFFFE, 4'b1010);
    issue(OP_XOR, 16'hF0F0, 16'hFFFF);
    chk_out("xor_b2b", 16'h0F0F, 4'b0000);

    issue(OP_MUL, 16'h0100, 16'h0100);
    chk("mul_busy_start", 32'(busy), 1);
    chk("mul_no_early_done", 32'(done), 0);
    wait_busy(bc);
    chk("mul_busy_cycles", 32'(bc), 16);
    chk_out("mul_hi", 16'h0000, 4'b0111);
    chk("mul_busy_low_at_done", 32'(busy), 0);

    issue(OP_MUL, 16'h00FF, 16'h0003);
    start = 1'b1; aluop = OP_ADD; valA = 16'h1234; valB = 16'h1111;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_busy(bc);
    chk("mul_ign_cycles", 32'(bc), 13);
    chk_out("mul_ign", 16'h02FD, 4'b0000);
    @(negedge clk);
    chk("mul_single_done", 32'(done), 0);

    issue(OP_DIV, 16'h0064, 16'h0007);
    wait_busy(bc);
    chk("div_busy_cycles", 32'(bc), 16);
    chk_out("div", 16'h000E, 4'b0000);

    issue(OP_DIV, 16'h1234, 16'h0000);
    chk("div0_no_busy", 32'(busy), 0);
    chk_out("div0", 16'hFFFF, 4'b1001);

    issue(OP_SHAR, 16'h8000, 16'h0013);
    chk_out("shar", 16'hF000, 4'b1000);
    issue(OP_RR, 16'h0001, 16'h0001);
    chk_out("rr", 16'h8000, 4'b1000);
    issue(OP_SHLR, 16'h8000, 16'h000F);
    chk_out("shlr", 16'h0001, 4'b0000);
    issue(OP_NOT, 16'h1234, 16'h0000);
    chk_out("not", 16'hFFFF, 4'b1000);
    issue(4'b0100, 16'h1234, 16'h5678);
    chk_out("undef", 16'h0000, 4'b0100);

    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    repeat (4) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",   32'(busy),   0);
    chk("abort_done",   32'(done),   0);
    chk("abort_result", 32'(result), 0);
    chk("abort_cc",     32'(cc),     0);
    bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) bc++;
    end
    chk("abort_no_done", 32'(bc), 0);

    reset = 1'b1;
    issue(OP_ADD, 16'h0001, 16'h0001);
    reset = 1'b0;
    chk("rst_start_done",   32'(done),   0);
    chk("rst_start_result", 32'(result), 0);

    start8 = 1'b1; aluop8 = OP_MUL; valA8 = 8'h10; valB8 = 8'h10;
    @(negedge clk);
    start8 = 1'b0;
    bc = 0;
    while (busy8 === 1'b1 && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    chk("mul8_busy_cycles", 32'(bc),      8);
    chk("mul8_done",        32'(done8),   1);
    chk("mul8_result",      32'(result8), 0);
    chk("mul8_cc",          32'(cc8),     32'(4'b0111));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
